// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush controls for PC, IF/ID, ID/EX, EX/MEM plus perf counters.
// Controls are combinational from state and inputs; state and counters update on the rising edge.
module pipeline_hazard_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_mc_start,
   input  logic             mem_req_pending,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             ex_mem_flush,
   output logic             ctrl_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int MW = ($clog2(MC_CYCLES) < 1) ? 1 : $clog2(MC_CYCLES);

   typedef enum logic {RUN, BUSY} state_t;

   state_t           state_q, state_d;
   logic [MW-1:0]    mc_cnt_q, mc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic mem_stall, load_use, mc_hold, mc_release, br_flush, lu_bubble;

   assign mem_stall = mem_req_pending & ~mem_ready;
   assign load_use  = ex_mem_read & (ex_rd_addr != 5'd0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

   // Priority chain: memory wait beats everything, then the multicycle op, then branch, then load-use.
   assign mc_hold    = ~mem_stall & (((state_q == RUN) & ex_mc_start) |
                                     ((state_q == BUSY) & (mc_cnt_q > MW'(1))));
   assign mc_release = ~mem_stall & (state_q == BUSY) & (mc_cnt_q <= MW'(1));
   assign br_flush   = ~mem_stall & (state_q == RUN) & ~ex_mc_start & ex_branch_taken;
   assign lu_bubble  = ~mem_stall & (state_q == RUN) & ~ex_mc_start & ~ex_branch_taken & load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         mc_cnt_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
         if (pc_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (br_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      mc_cnt_d = mc_cnt_q;
      if (!mem_stall) begin
         unique case (state_q)
            RUN: begin
               if (ex_mc_start) begin
                  state_d  = BUSY;
                  mc_cnt_d = MW'(MC_CYCLES - 1);
               end
            end
            BUSY: begin
               if (mc_cnt_q > MW'(1)) begin
                  mc_cnt_d = mc_cnt_q - MW'(1);
               end else begin
                  state_d  = RUN;
                  mc_cnt_d = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      ex_mem_flush = 1'b0;
      ctrl_busy    = 1'b0;
      stall_cycles = '0;
      flush_events = '0;
      if (!rst) begin
         ctrl_busy    = (state_q == BUSY);
         stall_cycles = stall_cnt_q;
         flush_events = flush_cnt_q;
         if (mem_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
         end else if (mc_hold) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (br_flush) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
         end else if (lu_bubble) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
         end
      end
   end

   logic unused_release;
   assign unused_release = mc_release;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vectors with literal expectations plus a per-cycle model check.
module tb_pipeline_hazard_ctrl;

   localparam int MC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mc_start;
   logic        mem_req_pending, mem_ready;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic        ex_mem_stall, ex_mem_flush, ctrl_busy;
   logic [31:0] stall_cycles, flush_events;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .mem_req_pending(mem_req_pending), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
      .ctrl_busy(ctrl_busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: op_age counts unstalled EX cycles of the current multicycle op (0 = no op).
   int          op_age = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;
   logic        ms, lu, in_op, br;
   logic [6:0]  exp_v, dut_v;

   always @(negedge clk) begin
      ms    = mem_req_pending & ~mem_ready;
      lu    = ex_mem_read && (ex_rd_addr != 5'd0) &&
              ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
      in_op = (op_age >= 1);
      br    = 1'b0;
      // bit order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall ex_mem_flush
      if (rst)                                                   exp_v = 7'b0000000;
      else if (ms)                                               exp_v = 7'b1101010;
      else if ((!in_op && ex_mc_start) || (in_op && op_age < MC - 1)) exp_v = 7'b1101001;
      else if (in_op)                                            exp_v = 7'b0000000;
      else if (ex_branch_taken) begin                            exp_v = 7'b0010100; br = 1'b1; end
      else if (lu)                                               exp_v = 7'b1100100;
      else                                                       exp_v = 7'b0000000;
      dut_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush};
      chk("ctrl_vec", {24'd0, dut_v, ctrl_busy}, {24'd0, exp_v, (!rst && in_op)});
      chk("stall_cycles", stall_cycles, rst ? 32'd0 : m_stall);
      chk("flush_events", flush_events, rst ? 32'd0 : m_flush);
      if (rst) begin
         op_age  = 0;
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (exp_v[6]) m_stall = m_stall + 32'd1;
         if (br)       m_flush = m_flush + 32'd1;
         if (!ms) begin
            if (in_op)            op_age = (op_age == MC - 1) ? 0 : op_age + 1;
            else if (ex_mc_start) op_age = 1;
         end
      end
   end

   task automatic idle();
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
      mem_req_pending = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu();
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, ctrl_busy}, 32'd0);
      chk("post_rst_cnt", stall_cycles, 32'd0);
      cyc();

      // load-use bubble
      set_lu();
      @(negedge clk);
      chk("lu_pc_stall", {31'd0, pc_stall}, 32'd1);
      chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
      chk("lu_id_ex_stall", {31'd0, id_ex_stall}, 32'd0);
      cyc(); idle();
      @(negedge clk);
      chk("lu_cleared", {31'd0, pc_stall}, 32'd0);
      chk("lu_stall_cnt", stall_cycles, 32'd1);
      cyc();

      // rd = x0, and rs1 matching but unused
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
      @(negedge clk);
      chk("lu_x0", {31'd0, pc_stall}, 32'd0);
      cyc();
      ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b0;
      @(negedge clk);
      chk("lu_unused_rs1", {31'd0, pc_stall}, 32'd0);
      cyc(); idle();

      // plain multicycle op
      ex_mc_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mc_id_ex_stall", {31'd0, id_ex_stall}, (i < 3) ? 32'd1 : 32'd0);
         chk("mc_ex_mem_flush", {31'd0, ex_mem_flush}, (i < 3) ? 32'd1 : 32'd0);
         chk("mc_busy", {31'd0, ctrl_busy}, (i > 0) ? 32'd1 : 32'd0);
         cyc();
      end
      ex_mc_start = 1'b0;
      @(negedge clk);
      chk("mc_stall_cnt", stall_cycles, 32'd4);
      chk("mc_idle_busy", {31'd0, ctrl_busy}, 32'd0);
      cyc();

      // multicycle op with a 2-cycle memory wait in its second cycle
      ex_mc_start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_req_pending = (i == 1 || i == 2);
         mem_ready = 1'b0;
         @(negedge clk);
         chk("mcm_pc_stall", {31'd0, pc_stall}, (i < 5) ? 32'd1 : 32'd0);
         chk("mcm_ex_mem_stall", {31'd0, ex_mem_stall}, (i == 1 || i == 2) ? 32'd1 : 32'd0);
         chk("mcm_ex_mem_flush", {31'd0, ex_mem_flush}, (i == 0 || i == 3 || i == 4) ? 32'd1 : 32'd0);
         cyc();
      end
      idle();
      @(negedge clk);
      chk("mcm_stall_cnt", stall_cycles, 32'd9);
      cyc();

      // branch wins over load-use
      set_lu(); ex_branch_taken = 1'b1;
      @(negedge clk);
      chk("br_if_id_flush", {31'd0, if_id_flush}, 32'd1);
      chk("br_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
      chk("br_pc_stall", {31'd0, pc_stall}, 32'd0);
      cyc(); idle();
      @(negedge clk);
      chk("br_flush_cnt", flush_events, 32'd1);
      cyc();
      // same with a memory wait: stall everything, no flush
      set_lu(); ex_branch_taken = 1'b1; mem_req_pending = 1'b1;
      @(negedge clk);
      chk("brm_pc_stall", {31'd0, pc_stall}, 32'd1);
      chk("brm_ex_mem_stall", {31'd0, ex_mem_stall}, 32'd1);
      chk("brm_if_id_flush", {31'd0, if_id_flush}, 32'd0);
      cyc(); idle();
      @(negedge clk);
      chk("brm_flush_cnt", flush_events, 32'd1);
      chk("brm_stall_cnt", stall_cycles, 32'd10);
      cyc();

      // reset in the middle of a multicycle op
      ex_mc_start = 1'b1;
      cyc();
      @(negedge clk);
      chk("rb_busy", {31'd0, ctrl_busy}, 32'd1);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("rb_pc_stall", {31'd0, pc_stall}, 32'd0);
      chk("rb_ex_mem_flush", {31'd0, ex_mem_flush}, 32'd0);
      chk("rb_busy_rst", {31'd0, ctrl_busy}, 32'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rb_after_busy", {31'd0, ctrl_busy}, 32'd0);
      chk("rb_after_cnt", stall_cycles, 32'd0);
      chk("rb_fresh_start", {31'd0, pc_stall}, 32'd1);
      cyc();
      @(negedge clk);
      chk("rb_fresh_busy", {31'd0, ctrl_busy}, 32'd1);
      cyc(); cyc(); cyc();
      ex_mc_start = 1'b0;

      // mixed vectors, checked by the per-cycle model
      repeat (300) begin
         id_rs1_addr     = 5'($urandom_range(0, 3));
         id_rs2_addr     = 5'($urandom_range(0, 3));
         ex_rd_addr      = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom);
         id_uses_rs2     = 1'($urandom);
         ex_mem_read     = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 3) == 0);
         ex_mc_start     = ($urandom_range(0, 4) == 0);
         mem_req_pending = ($urandom_range(0, 3) == 0);
         mem_ready       = 1'($urandom);
         rst             = ($urandom_range(0, 60) == 0);
         cyc();
      end
      idle();
      rst = 1'b0;
      cyc(); cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
